lif_stdp_pair: RTL and testbench

- Parametrised successor of the two-neuron LIF demo: a presynaptic and a postsynaptic leaky integrate-and-fire neuron joined by one plastic synapse.
- On-chip pair-based STDP learning: causal pairs (pre before post) potentiate the weight; anti-causal pairs (post before pre) depress it.
- Instantiated under the TinyTapeout top; spikes, membranes and weight are exposed for pin muxing.

---
 rtl/lif_stdp_pair.sv | 118 +++++++++++
 tb/tb_lif_stdp_pair.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_stdp_pair.sv
// rtl/lif_stdp_pair.sv - LIF pre/post neuron pair with a pair-based STDP synapse; STDP_DECAY_EN shrinks steps with spike distance
module lif_stdp_pair #(
  parameter int WIDTH      = 8,
  parameter int W_WIDTH    = 8,
  parameter int THRESH     = 200,
  parameter int LEAK_SHIFT = 3,
  parameter int TMAX       = 15,
  parameter int W_INIT     = 64,
  parameter int A_PLUS     = 4,
  parameter int A_MINUS    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               learn_en,
  input  logic [WIDTH-1:0]   cur_pre,
  input  logic [WIDTH-1:0]   cur_post,
  output logic               spike_pre,
  output logic               spike_post,
  output logic [WIDTH-1:0]   mem_pre,
  output logic [WIDTH-1:0]   mem_post,
  output logic [W_WIDTH-1:0] weight,
  output logic               w_upd
);

  localparam int TW = $clog2(TMAX + 2);
  localparam int SW = ((WIDTH > W_WIDTH) ? WIDTH : W_WIDTH) + 1;

  localparam logic [WIDTH:0]     MEM_MAX = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0]     THR     = (WIDTH + 1)'(THRESH);
  localparam logic [SW-1:0]      CUR_MAX = SW'(MEM_MAX);
  localparam logic [TW-1:0]      T_IDLE  = TW'(TMAX + 1);
  localparam logic [TW-1:0]      T_WIN   = TW'(TMAX);
  localparam logic [W_WIDTH:0]   W_MAX   = {1'b0, {W_WIDTH{1'b1}}};
  localparam logic [W_WIDTH-1:0] A_P     = W_WIDTH'(A_PLUS);
  localparam logic [W_WIDTH-1:0] A_M     = W_WIDTH'(A_MINUS);

  // One extra bit keeps leak+input overflow visible before the clamp.
  function automatic logic [WIDTH:0] leak_integrate(input logic [WIDTH-1:0] mem,
                                                    input logic [WIDTH-1:0] cur);
    logic [WIDTH:0] sum;
    sum = {1'b0, mem} - {1'b0, mem >> LEAK_SHIFT} + {1'b0, cur};
    return (sum > MEM_MAX) ? MEM_MAX : sum;
  endfunction

  function automatic logic [TW-1:0] timer_next(input logic fire, input logic [TW-1:0] t);
    if (fire) return '0;
    return (t == T_IDLE) ? t : t + TW'(1);
  endfunction

  logic [TW-1:0]      t_pre;
  logic [TW-1:0]      t_post;
  logic [SW-1:0]      post_sum;
  logic [WIDTH-1:0]   post_cur;
  logic [WIDTH:0]     cand_pre;
  logic [WIDTH:0]     cand_post;
  logic               fire_pre;
  logic               fire_post;

  always_comb begin
    post_sum  = SW'(cur_post) + (spike_pre ? SW'(weight) : '0);
    post_cur  = (post_sum > CUR_MAX) ? {WIDTH{1'b1}} : post_sum[WIDTH-1:0];
    cand_pre  = leak_integrate(mem_pre, cur_pre);
    cand_post = leak_integrate(mem_post, post_cur);
    fire_pre  = (cand_pre >= THR);
    fire_post = (cand_post >= THR);
  end

  logic [W_WIDTH-1:0] d_plus;
  logic [W_WIDTH-1:0] d_minus;
  logic [W_WIDTH:0]   w_sum;
  logic [W_WIDTH-1:0] w_next;
  logic               pot;
  logic               dep;

  // Pairing uses the registered spikes and timers, so the update lands one edge later.
  always_comb begin
`ifdef STDP_DECAY_EN
    d_plus  = A_P >> (t_pre >> 2);
    d_minus = A_M >> (t_post >> 2);
`else
    d_plus  = A_P;
    d_minus = A_M;
`endif
    pot    = learn_en && spike_post && !spike_pre && (t_pre != '0) && (t_pre <= T_WIN);
    dep    = learn_en && spike_pre && !spike_post && (t_post != '0) && (t_post <= T_WIN);
    w_sum  = {1'b0, weight} + {1'b0, d_plus};
    w_next = weight;
    if (pot) begin
      w_next = (w_sum > W_MAX) ? {W_WIDTH{1'b1}} : w_sum[W_WIDTH-1:0];
    end else if (dep) begin
      w_next = (weight > d_minus) ? weight - d_minus : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_pre    <= '0;
      mem_post   <= '0;
      spike_pre  <= 1'b0;
      spike_post <= 1'b0;
      t_pre      <= T_IDLE;
      t_post     <= T_IDLE;
      weight     <= W_WIDTH'(W_INIT);
      w_upd      <= 1'b0;
    end else if (ena) begin
      mem_pre    <= fire_pre ? '0 : cand_pre[WIDTH-1:0];
      mem_post   <= fire_post ? '0 : cand_post[WIDTH-1:0];
      spike_pre  <= fire_pre;
      spike_post <= fire_post;
      t_pre      <= timer_next(fire_pre, t_pre);
      t_post     <= timer_next(fire_post, t_post);
      weight     <= w_next;
      w_upd      <= (w_next != weight);
    end
  end

endmodule

// File: tb/tb_lif_stdp_pair.sv
// tb/tb_lif_stdp_pair.sv - directed and random checks of lif_stdp_pair against a spike-time reference model
module tb_lif_stdp_pair;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic       learn_en = 1'b1;
  logic [7:0] cur_pre = '0;
  logic [7:0] cur_post = '0;
  logic       spike_pre;
  logic       spike_post;
  logic [7:0] mem_pre;
  logic [7:0] mem_post;
  logic [7:0] weight;
  logic       w_upd;

  lif_stdp_pair dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .learn_en   (learn_en),
    .cur_pre    (cur_pre),
    .cur_post   (cur_post),
    .spike_pre  (spike_pre),
    .spike_post (spike_post),
    .mem_pre    (mem_pre),
    .mem_post   (mem_post),
    .weight     (weight),
    .w_upd      (w_upd)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: spike times are kept as absolute enabled-edge numbers.
  int m_mem_pre, m_mem_post, m_w, m_wupd, m_sp_pre, m_sp_post;
  int cyc, last_pre, last_post;
  int upd_cnt, spk_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int since(input int last);
    int age;
    age = cyc - last;
    return (age > 15) ? 16 : age;
  endfunction

  function automatic int step_mag(input int dt);
`ifdef STDP_DECAY_EN
    return 4 >> (dt / 4);
`else
    return 4 + 0 * dt;
`endif
  endfunction

  function automatic int integrate(input int mem, input int cur);
    int c;
    c = mem - (mem >> 3) + cur;
    return (c > 255) ? 255 : c;
  endfunction

  task automatic model_reset();
    m_mem_pre = 0; m_mem_post = 0; m_sp_pre = 0; m_sp_post = 0;
    m_w = 64; m_wupd = 0; cyc = 0; last_pre = -1000; last_post = -1000;
  endtask

  task automatic model_step();
    int dpre, dpost, nw, ipost, cp, cq;
    if (!ena) return;
    dpre  = since(last_pre);
    dpost = since(last_post);
    nw = m_w;
    if (learn_en && m_sp_post == 1 && m_sp_pre == 0 && dpre >= 1 && dpre <= 15)
      nw = (m_w + step_mag(dpre) > 255) ? 255 : m_w + step_mag(dpre);
    else if (learn_en && m_sp_pre == 1 && m_sp_post == 0 && dpost >= 1 && dpost <= 15)
      nw = (m_w - step_mag(dpost) < 0) ? 0 : m_w - step_mag(dpost);
    ipost = int'(cur_post) + ((m_sp_pre == 1) ? m_w : 0);
    if (ipost > 255) ipost = 255;
    cp = integrate(m_mem_pre, int'(cur_pre));
    cq = integrate(m_mem_post, ipost);
    cyc++;
    m_sp_pre  = (cp >= 200) ? 1 : 0;
    m_sp_post = (cq >= 200) ? 1 : 0;
    m_mem_pre  = (m_sp_pre == 1) ? 0 : cp;
    m_mem_post = (m_sp_post == 1) ? 0 : cq;
    if (m_sp_pre == 1) last_pre = cyc;
    if (m_sp_post == 1) last_post = cyc;
    m_wupd = (nw != m_w) ? 1 : 0;
    m_w = nw;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".mem_pre"}, 32'(mem_pre), m_mem_pre);
    chk({tag, ".mem_post"}, 32'(mem_post), m_mem_post);
    chk({tag, ".spike_pre"}, 32'(spike_pre), m_sp_pre);
    chk({tag, ".spike_post"}, 32'(spike_post), m_sp_post);
    chk({tag, ".weight"}, 32'(weight), m_w);
    chk({tag, ".w_upd"}, 32'(w_upd), m_wupd);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
    if (w_upd === 1'b1) upd_cnt++;
    if (spike_pre === 1'b1 || spike_post === 1'b1) spk_cnt++;
  endtask

  // Asserts reset between edges and checks it acted without a clock edge.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
    ena = 1'b1; learn_en = 1'b1; cur_pre = '0; cur_post = '0;
  endtask

  task automatic causal_pair(input int gap, input string tag);
    cur_pre = 8'd255; tick(tag);
    cur_pre = 8'd0;
    repeat (gap - 1) tick(tag);
    cur_post = 8'd255; tick(tag);
    cur_post = 8'd0;
    repeat (18) tick(tag);
  endtask

  task automatic anti_pair(input int gap, input string tag);
    cur_post = 8'd255; tick(tag);
    cur_post = 8'd0;
    repeat (gap - 1) tick(tag);
    cur_pre = 8'd255; tick(tag);
    cur_pre = 8'd0;
    repeat (18) tick(tag);
  endtask

  int integ_exp [8] = '{40, 75, 106, 133, 157, 178, 196, 0};

  initial begin
    do_reset("reset");

    // Integration ramp with constant current.
    cur_pre = 8'd40;
    for (int i = 0; i < 8; i++) begin
      tick("integ");
      chk("integ_mem", 32'(mem_pre), integ_exp[i]);
      chk("integ_spike", 32'(spike_pre), (i == 7) ? 1 : 0);
    end
    repeat (7) tick("integ2");
    tick("integ2");
    chk("integ_respike", 32'(spike_pre), 1);

    // Causal pair three cycles apart.
    do_reset("rst_causal");
    upd_cnt = 0;
    cur_pre = 8'd255; tick("causal");
    cur_pre = 8'd0; tick("causal"); tick("causal");
    cur_post = 8'd255; tick("causal");
    cur_post = 8'd0; tick("causal");
    chk("causal_weight", 32'(weight), 68);
    chk("causal_wupd", 32'(w_upd), 1);
    repeat (3) tick("causal");
    chk("causal_pulses", upd_cnt, 1);

    // Anti-causal pair five cycles apart.
    do_reset("rst_anti");
    cur_post = 8'd255; tick("anti");
    cur_post = 8'd0; repeat (4) tick("anti");
    cur_pre = 8'd255; tick("anti");
    cur_pre = 8'd0; tick("anti");
`ifdef STDP_DECAY_EN
    chk("anti_weight", 32'(weight), 62);
`else
    chk("anti_weight", 32'(weight), 60);
`endif
    chk("anti_wupd", 32'(w_upd), 1);

    // Out of window.
    do_reset("rst_oow");
    upd_cnt = 0;
    cur_pre = 8'd255; tick("oow");
    cur_pre = 8'd0; repeat (19) tick("oow");
    cur_post = 8'd255; tick("oow");
    cur_post = 8'd0; repeat (3) tick("oow");
    chk("oow_pulses", upd_cnt, 0);
    chk("oow_weight", 32'(weight), 64);

    // Simultaneous spikes.
    do_reset("rst_sim");
    upd_cnt = 0;
    cur_pre = 8'd255; cur_post = 8'd255; tick("sim");
    chk("sim_both", 32'({spike_pre, spike_post}), 3);
    cur_pre = 8'd0; cur_post = 8'd0; repeat (3) tick("sim");
    chk("sim_pulses", upd_cnt, 0);
    chk("sim_weight", 32'(weight), 64);

    // Upper saturation.
    do_reset("rst_sat_hi");
    repeat (48) causal_pair(1, "sat_hi");
    chk("sat_hi_weight", 32'(weight), 255);
    upd_cnt = 0;
    causal_pair(1, "sat_hi_extra");
    chk("sat_hi_pulses", upd_cnt, 0);
    chk("sat_hi_hold", 32'(weight), 255);

    // Lower saturation.
    do_reset("rst_sat_lo");
    repeat (16) anti_pair(1, "sat_lo");
    chk("sat_lo_weight", 32'(weight), 0);
    upd_cnt = 0;
    anti_pair(1, "sat_lo_extra");
    chk("sat_lo_pulses", upd_cnt, 0);

    // Clock-enable hold mid-integration.
    do_reset("rst_ena");
    cur_pre = 8'd40;
    repeat (4) tick("ena_run");
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cur_pre = 8'($urandom_range(0, 255));
      cur_post = 8'($urandom_range(0, 255));
      tick("ena_hold");
      chk("ena_hold_mem", 32'(mem_pre), 133);
    end
    ena = 1'b1; cur_pre = 8'd40; cur_post = 8'd0;
    tick("ena_resume");
    chk("ena_resume_mem", 32'(mem_pre), 157);

    // Reset while a spike is being shown.
    cur_pre = 8'd255; tick("pre_rst");
    chk("pre_rst_spike", 32'(spike_pre), 1);
    do_reset("rst_mid_spike");
    chk("rst_mid_weight", 32'(weight), 64);

    // Learning disabled.
    learn_en = 1'b0;
    spk_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      cur_pre = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 60));
      cur_post = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 60));
      tick("nolearn");
    end
    chk("nolearn_weight", 32'(weight), 64);
    chk("nolearn_spiked", 32'(spk_cnt > 0), 1);

    // Random mix against the model.
    do_reset("rst_rand");
    for (int i = 0; i < 800; i++) begin
      ena = ($urandom_range(0, 9) != 0);
      learn_en = ($urandom_range(0, 5) != 0);
      cur_pre = ($urandom_range(0, 4) == 0) ? 8'd255 : 8'($urandom_range(0, 90));
      cur_post = ($urandom_range(0, 4) == 0) ? 8'd255 : 8'($urandom_range(0, 90));
      tick("rand");
      if (i == 400) do_reset("rst_rand_mid");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
